// File: rtl/mmio_pkg.sv
// Shared types and address map for the MMIO bus arbiter slice.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Master identifier: 0 = CPU, 1 = secondary requester (debug/DMA).
    typedef logic mid_t;

    localparam mid_t MID_CPU = 1'b0;
    localparam mid_t MID_AUX = 1'b1;

    localparam logic [15:0] MMIO_LED_ADDR = 16'hC000;
    localparam logic [15:0] MMIO_SW_ADDR  = 16'hC001;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; the priority pointer lives in the caller.
module rr_arb2
    import mmio_pkg::*;
(
    input  logic [1:0] req_i,
    input  mid_t       last_grant_i,
    output logic       valid_o,
    output mid_t       winner_o
);

    // On a tie the master that was not served last wins; otherwise the lone requester.
    always_comb begin
        valid_o  = |req_i;
        winner_o = MID_CPU;
        if (req_i == 2'b11) begin
            winner_o = ~last_grant_i;
        end else if (req_i[1]) begin
            winner_o = MID_AUX;
        end
    end

endmodule

// File: rtl/mmio_bus_arb.sv
// Two-master arbiter and sequencer for the shared MMIO bus: grants round-robin,
// runs one peripheral access with wait states and a timeout, returns data or error.
module mmio_bus_arb
    import mmio_pkg::*;
#(
    parameter int             DW        = 16,
    parameter int             AW        = 16,
    parameter logic [AW-1:0]  MMIO_BASE = AW'(MMIO_LED_ADDR),
    parameter logic [AW-1:0]  MMIO_MASK = 16'hFFF0,
    parameter int             TIMEOUT   = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          p_re,
    output logic          p_we,
    output logic [AW-1:0] p_addr,
    output logic [DW-1:0] p_wdata,
    input  logic [DW-1:0] p_rdata,
    input  logic          p_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    mid_t          id_q, id_d;
    mid_t          last_q, last_d;
    logic          we_l_q, we_l_d;
    logic [AW-1:0] addr_l_q, addr_l_d;
    logic [DW-1:0] wdata_l_q, wdata_l_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          err0_q, err0_d, err1_q, err1_d;

    logic          arb_vld;
    mid_t          arb_win;
    logic          hit;
    logic          acc_hit;
    logic          cap;
    logic [DW-1:0] cap_rdata;
    logic          cap_err;

    rr_arb2 u_rr_arb2 (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_q),
        .valid_o      (arb_vld),
        .winner_o     (arb_win)
    );

    assign hit     = ((addr_l_q & MMIO_MASK) == (MMIO_BASE & MMIO_MASK));
    assign acc_hit = (state_q == ACCESS) && hit;

    // Next-state, command latch and result capture.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        last_d    = last_q;
        we_l_d    = we_l_q;
        addr_l_d  = addr_l_q;
        wdata_l_d = wdata_l_q;
        cnt_d     = cnt_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        err0_d    = err0_q;
        err1_d    = err1_q;
        cap       = 1'b0;
        cap_rdata = '0;
        cap_err   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    id_d      = arb_win;
                    we_l_d    = (arb_win == MID_AUX) ? m1_we    : m0_we;
                    addr_l_d  = (arb_win == MID_AUX) ? m1_addr  : m0_addr;
                    wdata_l_d = (arb_win == MID_AUX) ? m1_wdata : m0_wdata;
                    gnt0_d    = (arb_win == MID_CPU);
                    gnt1_d    = (arb_win == MID_AUX);
                    cnt_d     = '0;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (!hit) begin
                    cap     = 1'b1;
                    cap_err = 1'b1;
                    state_d = DONE;
                end else if (p_ready) begin
                    cap       = 1'b1;
                    cap_rdata = we_l_q ? '0 : p_rdata;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        cap     = 1'b1;
                        cap_err = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_d  = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cap) begin
            if (id_q == MID_AUX) begin
                rdata1_d = cap_rdata;
                err1_d   = cap_err;
            end else begin
                rdata0_d = cap_rdata;
                err0_d   = cap_err;
            end
        end
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            id_q      <= MID_CPU;
            last_q    <= MID_AUX;
            we_l_q    <= 1'b0;
            addr_l_q  <= '0;
            wdata_l_q <= '0;
            cnt_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            last_q    <= last_d;
            we_l_q    <= we_l_d;
            addr_l_q  <= addr_l_d;
            wdata_l_q <= wdata_l_d;
            cnt_q     <= cnt_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    // Bus strobes and address only drive during a decoded access; zero otherwise.
    assign p_re    = acc_hit && !we_l_q;
    assign p_we    = acc_hit && we_l_q;
    assign p_addr  = acc_hit ? addr_l_q  : '0;
    assign p_wdata = acc_hit ? wdata_l_q : '0;

    assign m0_gnt   = gnt0_q;
    assign m1_gnt   = gnt1_q;
    assign m0_done  = (state_q == DONE) && (id_q == MID_CPU);
    assign m1_done  = (state_q == DONE) && (id_q == MID_AUX);
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign m0_err   = err0_q;
    assign m1_err   = err1_q;

endmodule

// File: tb/tb_mmio_bus_arb.sv
// Directed bench for mmio_bus_arb.
module tb_mmio_bus_arb;
    import mmio_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_gnt, m0_done, m0_err;
    logic [15:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_done, m1_err;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;
    logic        p_re, p_we, p_ready;
    logic [15:0] p_addr, p_wdata, p_rdata;

    int checks = 0;
    int fails  = 0;

    mmio_bus_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .p_re(p_re), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ready(p_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        p_ready = 0; p_rdata = '0;
        step(); step();
        checks++; if ({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, p_re, p_we} !== 8'h00) begin
            fails++; $display("FAIL reset_ctrl: got %b want 00000000", {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, p_re, p_we}); end
        checks++; if ({p_addr, p_wdata, m0_rdata, m1_rdata} !== 64'h0) begin
            fails++; $display("FAIL reset_data: got %h want 0", {p_addr, p_wdata, m0_rdata, m1_rdata}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_m0_write();
        p_ready = 1;
        m0_req = 1; m0_we = 1; m0_addr = MMIO_LED_ADDR; m0_wdata = 16'h03A5;
        step();
        m0_req = 0;
        #1;
        checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            fails++; $display("FAIL wr_gnt: got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt); end
        checks++; if ({p_we, p_re} !== 2'b10 || p_addr !== 16'hC000 || p_wdata !== 16'h03A5) begin
            fails++; $display("FAIL wr_bus: got we=%b re=%b addr=%h wdata=%h want 1 0 c000 03a5", p_we, p_re, p_addr, p_wdata); end
        checks++; if (m0_done !== 1'b0) begin
            fails++; $display("FAIL wr_early_done: got %b want 0", m0_done); end
        step();
        checks++; if (m0_done !== 1'b1 || m0_err !== 1'b0 || m0_gnt !== 1'b0 || p_we !== 1'b0) begin
            fails++; $display("FAIL wr_done: got done=%b err=%b gnt=%b p_we=%b want 1 0 0 0", m0_done, m0_err, m0_gnt, p_we); end
        checks++; if (m0_rdata !== 16'h0000) begin
            fails++; $display("FAIL wr_rdata: got %h want 0000", m0_rdata); end
        step();
        checks++; if (m0_done !== 1'b0 || p_addr !== 16'h0) begin
            fails++; $display("FAIL wr_idle: got done=%b addr=%h want 0 0000", m0_done, p_addr); end
    endtask

    task automatic test_m1_read_wait();
        p_ready = 0; p_rdata = 16'h0155;
        m1_req = 1; m1_we = 0; m1_addr = MMIO_SW_ADDR;
        step();
        m1_req = 0;
        #1;
        checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
            fails++; $display("FAIL rd_gnt: got m1=%b m0=%b want 1 0", m1_gnt, m0_gnt); end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                p_ready = 1;
                #1;
            end
            checks++; if (p_re !== 1'b1 || p_we !== 1'b0 || p_addr !== 16'hC001 || m1_done !== 1'b0) begin
                fails++; $display("FAIL rd_hold%0d: got re=%b we=%b addr=%h done=%b want 1 0 c001 0", i, p_re, p_we, p_addr, m1_done); end
            if (i < 3) step();
        end
        step();
        p_ready = 0;
        checks++; if (m1_done !== 1'b1 || m1_rdata !== 16'h0155 || m1_err !== 1'b0 || m0_done !== 1'b0) begin
            fails++; $display("FAIL rd_done: got done=%b rdata=%h err=%b m0_done=%b want 1 0155 0 0", m1_done, m1_rdata, m1_err, m0_done); end
        checks++; if (p_re !== 1'b0) begin
            fails++; $display("FAIL rd_strobe_off: got %b want 0", p_re); end
        step();
    endtask

    task automatic test_round_robin();
        int n;
        int got;
        rst_n = 0;
        m0_req = 1; m0_we = 0; m0_addr = MMIO_LED_ADDR;
        m1_req = 1; m1_we = 0; m1_addr = MMIO_SW_ADDR;
        p_ready = 1; p_rdata = 16'h5A5A;
        step();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            step();
            while (!(m0_gnt || m1_gnt) && n < 10) begin
                step();
                n++;
            end
            got = m1_gnt ? 1 : 0;
            checks++; if (n >= 10 || (m0_gnt && m1_gnt) || got != (k % 2)) begin
                fails++; $display("FAIL rr_order%0d: got m0_gnt=%b m1_gnt=%b wait=%0d want master %0d", k, m0_gnt, m1_gnt, n, k % 2); end
            step();
            if (k == 3) begin
                m0_req = 0; m1_req = 0;
            end
            checks++; if ((k % 2 == 0 && {m0_done, m1_done} !== 2'b10) || (k % 2 == 1 && {m0_done, m1_done} !== 2'b01)) begin
                fails++; $display("FAIL rr_done%0d: got m0_done=%b m1_done=%b want master %0d", k, m0_done, m1_done, k % 2); end
            checks++; if ((k % 2 == 0 && m0_rdata !== 16'h5A5A) || (k % 2 == 1 && m1_rdata !== 16'h5A5A)) begin
                fails++; $display("FAIL rr_rdata%0d: got m0=%h m1=%h want 5a5a", k, m0_rdata, m1_rdata); end
        end
        step();
        step();
        checks++; if ({m0_gnt, m1_gnt, p_re} !== 3'b000) begin
            fails++; $display("FAIL rr_settle: got %b want 000", {m0_gnt, m1_gnt, p_re}); end
    endtask

    task automatic test_timeout();
        int cyc;
        p_ready = 0; p_rdata = 16'hFFFF;
        m0_req = 1; m0_we = 0; m0_addr = 16'hC002;
        step();
        m0_req = 0;
        cyc = 0;
        while (p_re === 1'b1 && cyc < 40) begin
            cyc++;
            step();
        end
        checks++; if (cyc != 15) begin
            fails++; $display("FAIL to_cycles: got %0d want 15", cyc); end
        checks++; if (m0_done !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 16'h0000) begin
            fails++; $display("FAIL to_done: got done=%b err=%b rdata=%h want 1 1 0000", m0_done, m0_err, m0_rdata); end
        step();
        checks++; if (m0_done !== 1'b0 || p_re !== 1'b0 || p_addr !== 16'h0) begin
            fails++; $display("FAIL to_idle: got done=%b re=%b addr=%h want 0 0 0000", m0_done, p_re, p_addr); end
    endtask

    task automatic test_miss();
        p_ready = 1; p_rdata = 16'h1234;
        m0_req = 1; m0_we = 0; m0_addr = MMIO_SW_ADDR;
        step();
        m0_req = 0;
        step();
        checks++; if (m0_done !== 1'b1 || m0_rdata !== 16'h1234 || m0_err !== 1'b0) begin
            fails++; $display("FAIL pre_miss_rd: got done=%b rdata=%h err=%b want 1 1234 0", m0_done, m0_rdata, m0_err); end
        step();
        m0_req = 1; m0_we = 0; m0_addr = 16'h1000;
        step();
        m0_req = 0;
        checks++; if (m0_gnt !== 1'b1 || p_re !== 1'b0 || p_we !== 1'b0 || p_addr !== 16'h0) begin
            fails++; $display("FAIL miss_bus: got gnt=%b re=%b we=%b addr=%h want 1 0 0 0000", m0_gnt, p_re, p_we, p_addr); end
        step();
        checks++; if (m0_done !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 16'h0000) begin
            fails++; $display("FAIL miss_done: got done=%b err=%b rdata=%h want 1 1 0000", m0_done, m0_err, m0_rdata); end
        checks++; if (m1_rdata !== 16'h5A5A || m1_err !== 1'b0) begin
            fails++; $display("FAIL miss_m1_hold: got rdata=%h err=%b want 5a5a 0", m1_rdata, m1_err); end
        step();
    endtask

    task automatic test_reset_mid();
        p_ready = 0; p_rdata = 16'h7777;
        m1_req = 1; m1_we = 0; m1_addr = MMIO_SW_ADDR;
        step();
        m1_req = 0;
        checks++; if (m1_gnt !== 1'b1 || p_re !== 1'b1) begin
            fails++; $display("FAIL rm_start: got gnt=%b re=%b want 1 1", m1_gnt, p_re); end
        step();
        rst_n = 0;
        #1;
        checks++; if ({p_re, p_we, m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err} !== 8'h00 || p_addr !== 16'h0 || m1_rdata !== 16'h0) begin
            fails++; $display("FAIL rm_abort: got ctrl=%b addr=%h m1_rdata=%h want 0 0000 0000", {p_re, p_we, m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err}, p_addr, m1_rdata); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (m1_done !== 1'b0 || m0_done !== 1'b0 || p_re !== 1'b0) begin
                fails++; $display("FAIL rm_nodone%0d: got m0=%b m1=%b re=%b want 0 0 0", i, m0_done, m1_done, p_re); end
        end
        p_ready = 1;
        m0_req = 1; m0_we = 1; m0_addr = MMIO_LED_ADDR; m0_wdata = 16'h0001;
        m1_req = 1; m1_we = 0; m1_addr = MMIO_SW_ADDR;
        rst_n = 1;
        step();
        m0_req = 0; m1_req = 0;
        checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || p_we !== 1'b1 || p_wdata !== 16'h0001) begin
            fails++; $display("FAIL rm_m0_wins: got m0=%b m1=%b we=%b wdata=%h want 1 0 1 0001", m0_gnt, m1_gnt, p_we, p_wdata); end
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_m0_write();
        test_m1_read_wait();
        test_round_robin();
        test_timeout();
        test_miss();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
